// File: rtl/pmu_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single counter slave.
// Each transfer runs IDLE -> GRANT -> RESP and ends in a ready pulse, an err pulse on timeout, or an abort.
module pmu_bus_arbiter #(
    parameter int WORD_SIZE    = 32,
    parameter int WHISBONE_ADR = 32,
    parameter int TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_valid_i,
    input  logic                    m0_we_i,
    input  logic [3:0]              m0_wstrb_i,
    input  logic [WORD_SIZE-1:0]    m0_wdata_i,
    input  logic [WHISBONE_ADR-1:0] m0_adr_i,
    output logic                    m0_ready_o,
    output logic                    m0_err_o,
    output logic [WORD_SIZE-1:0]    m0_rdata_o,
    input  logic                    m1_valid_i,
    input  logic                    m1_we_i,
    input  logic [3:0]              m1_wstrb_i,
    input  logic [WORD_SIZE-1:0]    m1_wdata_i,
    input  logic [WHISBONE_ADR-1:0] m1_adr_i,
    output logic                    m1_ready_o,
    output logic                    m1_err_o,
    output logic [WORD_SIZE-1:0]    m1_rdata_o,
    output logic                    s_valid_o,
    output logic                    s_we_o,
    output logic [3:0]              s_wstrb_o,
    output logic [WORD_SIZE-1:0]    s_wdata_o,
    output logic [WHISBONE_ADR-1:0] s_adr_o,
    input  logic                    s_ready_i,
    input  logic [WORD_SIZE-1:0]    s_rdata_i
);

    typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

    state_t                  state, state_nx;
    logic [7:0]              wait_cnt, wait_cnt_nx;
    logic                    last_grant, last_grant_nx;
    logic                    grantee, grantee_nx;
    logic                    pick;
    logic                    cur_valid;

    logic                    s_valid_nx, s_we_nx;
    logic [3:0]              s_wstrb_nx;
    logic [WORD_SIZE-1:0]    s_wdata_nx;
    logic [WHISBONE_ADR-1:0] s_adr_nx;
    logic                    m0_ready_nx, m0_err_nx, m1_ready_nx, m1_err_nx;
    logic [WORD_SIZE-1:0]    m0_rdata_nx, m1_rdata_nx;

    // On a tie the master that did not win last time gets the bus.
    assign pick      = (m0_valid_i && m1_valid_i) ? ~last_grant : m1_valid_i;
    assign cur_valid = grantee ? m1_valid_i : m0_valid_i;

    always_comb begin
        state_nx      = state;
        wait_cnt_nx   = wait_cnt;
        last_grant_nx = last_grant;
        grantee_nx    = grantee;
        s_valid_nx    = s_valid_o;
        s_we_nx       = s_we_o;
        s_wstrb_nx    = s_wstrb_o;
        s_wdata_nx    = s_wdata_o;
        s_adr_nx      = s_adr_o;
        m0_ready_nx   = 1'b0;
        m0_err_nx     = 1'b0;
        m1_ready_nx   = 1'b0;
        m1_err_nx     = 1'b0;
        m0_rdata_nx   = m0_rdata_o;
        m1_rdata_nx   = m1_rdata_o;

        case (state)
            IDLE: begin
                if (m0_valid_i || m1_valid_i) begin
                    grantee_nx    = pick;
                    last_grant_nx = pick;
                    s_valid_nx    = 1'b1;
                    s_we_nx       = pick ? m1_we_i    : m0_we_i;
                    s_wstrb_nx    = pick ? m1_wstrb_i : m0_wstrb_i;
                    s_wdata_nx    = pick ? m1_wdata_i : m0_wdata_i;
                    s_adr_nx      = pick ? m1_adr_i   : m0_adr_i;
                    wait_cnt_nx   = 8'd0;
                    state_nx      = GRANT;
                end
            end
            GRANT: begin
                if (wait_cnt != 8'hFF)
                    wait_cnt_nx = wait_cnt + 8'd1;
                // A ready seen at count zero is left over from the previous transfer.
                if (!cur_valid) begin
                    s_valid_nx = 1'b0;
                    state_nx   = RESP;
                end else if (wait_cnt != 8'd0 && s_ready_i) begin
                    s_valid_nx = 1'b0;
                    state_nx   = RESP;
                    if (grantee) begin
                        m1_ready_nx = 1'b1;
                        if (!s_we_o) m1_rdata_nx = s_rdata_i;
                    end else begin
                        m0_ready_nx = 1'b1;
                        if (!s_we_o) m0_rdata_nx = s_rdata_i;
                    end
                end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                    s_valid_nx = 1'b0;
                    state_nx   = RESP;
                    if (grantee) begin
                        m1_ready_nx = 1'b1;
                        m1_err_nx   = 1'b1;
                        if (!s_we_o) m1_rdata_nx = '0;
                    end else begin
                        m0_ready_nx = 1'b1;
                        m0_err_nx   = 1'b1;
                        if (!s_we_o) m0_rdata_nx = '0;
                    end
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= 8'd0;
            last_grant <= 1'b1;
            grantee    <= 1'b0;
            s_valid_o  <= 1'b0;
            s_we_o     <= 1'b0;
            s_wstrb_o  <= '0;
            s_wdata_o  <= '0;
            s_adr_o    <= '0;
            m0_ready_o <= 1'b0;
            m0_err_o   <= 1'b0;
            m1_ready_o <= 1'b0;
            m1_err_o   <= 1'b0;
            m0_rdata_o <= '0;
            m1_rdata_o <= '0;
        end else begin
            state      <= state_nx;
            wait_cnt   <= wait_cnt_nx;
            last_grant <= last_grant_nx;
            grantee    <= grantee_nx;
            s_valid_o  <= s_valid_nx;
            s_we_o     <= s_we_nx;
            s_wstrb_o  <= s_wstrb_nx;
            s_wdata_o  <= s_wdata_nx;
            s_adr_o    <= s_adr_nx;
            m0_ready_o <= m0_ready_nx;
            m0_err_o   <= m0_err_nx;
            m1_ready_o <= m1_ready_nx;
            m1_err_o   <= m1_err_nx;
            m0_rdata_o <= m0_rdata_nx;
            m1_rdata_o <= m1_rdata_nx;
        end
    end

endmodule

// File: doc/pmu_bus_arbiter.md
PMU_BUS_ARBITER -- requirements
Module: pmu_bus_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 32, data width of all data ports.
REQ-002 Parameter WHISBONE_ADR, default 32, address width of all address ports.
REQ-003 Parameter TIMEOUT, default 16, maximum wait cycles for slave ready (range 2..255).
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 m0_valid_i, m1_valid_i  input  1 each  master request; held high with fields stable until that master's ready/err pulse.
REQ-007 m0_we_i, m1_we_i  input  1 each  1 = write, 0 = read.
REQ-008 m0_wstrb_i, m1_wstrb_i  input  4 each  byte strobes.
REQ-009 m0_wdata_i, m1_wdata_i  input  WORD_SIZE each  write data.
REQ-010 m0_adr_i, m1_adr_i  input  WHISBONE_ADR each  address.
REQ-011 m0_ready_o, m1_ready_o  output  1 each  one-cycle completion pulse.
REQ-012 m0_err_o, m1_err_o  output  1 each  one-cycle timeout pulse, coincident with ready.
REQ-013 m0_rdata_o, m1_rdata_o  output  WORD_SIZE each  read data.
REQ-014 s_valid_o, s_we_o  output  1 each  request to shared counter slave.
REQ-015 s_wstrb_o  output  4; s_wdata_o  output  WORD_SIZE; s_adr_o  output  WHISBONE_ADR  forwarded fields.
REQ-016 s_ready_i  input  1  slave ready (level, asserted cycle after valid, may linger one cycle after valid drops).
REQ-017 s_rdata_i  input  WORD_SIZE  slave read data, valid when s_ready_i high.

Function
REQ-018 FSM states IDLE, GRANT, RESP; all outputs registered.
REQ-019 IDLE: if any valid, grant at next edge, latch grantee's fields onto s_* outputs, s_valid_o=1, wait counter=0, go GRANT.
REQ-020 Arbitration: round-robin; single requester wins; both requesting -> grant master not in last_grant; last_grant updated on every grant.
REQ-021 GRANT: wait counter increments each cycle; s_ready_i ignored while counter==0 (stale ready from prior transfer).
REQ-022 GRANT with counter>=1 and s_ready_i=1: next edge s_valid_o=0, grantee ready_o=1 for one cycle, grantee rdata_o<=s_rdata_i on read only (write leaves rdata_o unchanged), go RESP.
REQ-023 GRANT with counter==TIMEOUT-1 and no ready: next edge s_valid_o=0, grantee ready_o=1 and err_o=1, grantee rdata_o<=0 on read, go RESP.
REQ-024 GRANT and grantee drops valid (abort): next edge s_valid_o=0, no ready/err pulse, go RESP.
REQ-025 RESP: lasts exactly one cycle, ready/err cleared at its end, go IDLE; new grant earliest from IDLE next cycle.
REQ-026 Latency with slave ready at counter==1: valid in IDLE cycle t -> s_valid_o high t+1..t+2, ready_o pulse cycle t+3; next grant s_valid_o at t+5.
REQ-027 Non-granted master receives no pulse and its rdata_o holds; ready/err never asserted to both masters in one cycle.
REQ-028 Wait counter 8 bits, saturating; no wrap.

Reset
REQ-029 rst high at any edge, including mid-GRANT: state=IDLE, counter=0, last_grant=1 (m0 wins first tie), s_valid_o=0, s_we_o=0, s_wstrb_o=0, s_wdata_o=0, s_adr_o=0, all ready/err=0, all rdata_o=0; aborted transfer produces no pulse.

Verification
REQ-030 m0 read adr 32'h3000_0000, slave ready at counter 1 with rdata 32'h0000_00A5 -> m0_ready_o pulse cycle t+3, m0_rdata_o=32'h0000_00A5, m1 outputs unchanged.
REQ-031 Both masters valid from reset -> m0 granted first, then m1; repeat both -> m0, m1 alternate over 4 transfers.
REQ-032 m1 write wdata 32'h1234_5678 wstrb 4'b0011 -> s_wdata_o/s_wstrb_o match for whole GRANT, m1_ready_o pulse, m1_rdata_o unchanged.
REQ-033 Slave never ready, TIMEOUT=16 -> m0_ready_o and m0_err_o pulse at cycle t+17, m0_rdata_o=0, s_valid_o low.
REQ-034 Slave ready held high across back-to-back transfers -> stale ready at counter 0 ignored; each transfer still completes at counter 1.
REQ-035 rst asserted during GRANT -> no ready pulse, all outputs at reset values next cycle, next tie grants m0.
